// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared state encoding and field widths for the op scheduler
package sched_pkg;

    localparam int OP_W   = 3;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC    = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/op_scheduler_if.sv
// rtl/op_scheduler_if.sv - requester, ALU, UART and completion signals of the op scheduler
interface op_scheduler_if;
    import sched_pkg::*;

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [15:0]         req_a;
    logic [15:0]         req_b;
    logic [2*OP_W-1:0]   req_op;

    logic [BYTE_W-1:0]   alu_a;
    logic [BYTE_W-1:0]   alu_b;
    logic [OP_W-1:0]     alu_op;
    logic                alu_ena;
    logic [15:0]         alu_result;

    logic                uart_start;
    logic [BYTE_W-1:0]   uart_data;
    logic                uart_busy;

    logic                done;
    logic                done_id;
    logic [15:0]         done_result;
    logic                done_err;

    modport master (
        input  req_valid, req_a, req_b, req_op, alu_result, uart_busy,
        output req_ready, alu_a, alu_b, alu_op, alu_ena,
               uart_start, uart_data, done, done_id, done_result, done_err
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, alu_result, uart_busy,
        input  req_ready, alu_a, alu_b, alu_op, alu_ena,
               uart_start, uart_data, done, done_id, done_result, done_err
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter, combinational grant plus priority register
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_en,
    input  logic       i_update,
    input  logic       i_last_id,
    output logic [1:0] o_gnt
);

    // r_prio names the requester that currently wins a tie
    logic r_prio;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (i_update) begin
            r_prio <= ~i_last_id;
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (r_prio == 1'b0) begin
                o_gnt = i_req[0] ? 2'b01 : (i_req[1] ? 2'b10 : 2'b00);
            end else begin
                o_gnt = i_req[1] ? 2'b10 : (i_req[0] ? 2'b01 : 2'b00);
            end
        end
    end

endmodule

// File: rtl/op_scheduler.sv
// rtl/op_scheduler.sv - arbitrates two job requesters, runs one ALU op per job and ships the result over UART
module op_scheduler
    import sched_pkg::*;
#(
    parameter int SEND_BYTES   = 2,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ena,
    op_scheduler_if.master        bus
);

    localparam logic LAST_BYTE = (SEND_BYTES > 1);

    state_t              r_state;
    state_t              w_next;
    logic [BYTE_W-1:0]   r_a;
    logic [BYTE_W-1:0]   r_b;
    logic [OP_W-1:0]     r_op;
    logic                r_id;
    logic [15:0]         r_result;
    logic                r_byte;
    logic                r_err;
    logic [7:0]          r_tmo;
    logic                r_hold_id;
    logic [15:0]         r_hold_result;
    logic                r_hold_err;

    logic [1:0]          w_gnt;
    logic                w_sel;
    logic                w_arb_en;
    logic                w_update;

    assign w_arb_en = ena && !reset && (r_state == IDLE);
    assign w_update = ena && (r_state == DONE);
    assign w_sel    = w_gnt[1];

    rr_arb2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .i_req     (bus.req_valid),
        .i_en      (w_arb_en),
        .i_update  (w_update),
        .i_last_id (r_id),
        .o_gnt     (w_gnt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.req_ready   = w_gnt;
        bus.alu_ena     = 1'b0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_op      = '0;
        bus.uart_start  = 1'b0;
        bus.uart_data   = '0;
        bus.done        = 1'b0;
        bus.done_id     = r_hold_id;
        bus.done_result = r_hold_result;
        bus.done_err    = r_hold_err;

        if (r_state != IDLE) begin
            bus.alu_ena = 1'b1;
            bus.alu_a   = r_a;
            bus.alu_b   = r_b;
            bus.alu_op  = r_op;
        end
        if (r_state == START || r_state == WAIT_HI) begin
            bus.uart_start = 1'b1;
            bus.uart_data  = r_byte ? r_result[15:8] : r_result[7:0];
        end
        // The completion report is live in DONE and frozen in the hold registers afterwards
        if (r_state == DONE && ena) begin
            bus.done        = 1'b1;
            bus.done_id     = r_id;
            bus.done_result = r_result;
            bus.done_err    = r_err;
        end

        if (!ena) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (|w_gnt) w_next = EXEC;
                EXEC:    w_next = START;
                START:   w_next = WAIT_HI;
                WAIT_HI: begin
                    if (bus.uart_busy) begin
                        w_next = WAIT_LO;
                    end else if (r_tmo <= 8'd1) begin
                        w_next = DONE;
                    end
                end
                WAIT_LO: begin
                    if (!bus.uart_busy) begin
                        w_next = (r_byte == LAST_BYTE) ? DONE : START;
                    end
                end
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_id          <= 1'b0;
            r_result      <= '0;
            r_byte        <= 1'b0;
            r_err         <= 1'b0;
            r_tmo         <= '0;
            r_hold_id     <= 1'b0;
            r_hold_result <= '0;
            r_hold_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_a    <= w_sel ? bus.req_a[15:8] : bus.req_a[7:0];
                        r_b    <= w_sel ? bus.req_b[15:8] : bus.req_b[7:0];
                        r_op   <= w_sel ? bus.req_op[2*OP_W-1:OP_W] : bus.req_op[OP_W-1:0];
                        r_id   <= w_sel;
                        r_byte <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                EXEC:  r_result <= bus.alu_result;
                START: r_tmo    <= 8'(BUSY_TIMEOUT);
                WAIT_HI: begin
                    if (!bus.uart_busy) begin
                        if (r_tmo <= 8'd1) begin
                            r_err <= 1'b1;
                        end else begin
                            r_tmo <= r_tmo - 8'd1;
                        end
                    end
                end
                WAIT_LO: begin
                    if (!bus.uart_busy && r_byte != LAST_BYTE) begin
                        r_byte <= 1'b1;
                    end
                end
                DONE: begin
                    if (ena) begin
                        r_hold_id     <= r_id;
                        r_hold_result <= r_result;
                        r_hold_err    <= r_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
